fault_injector: RTL and testbench

Parametrised, runtime-configurable fault-injection stage that sits between a codeword producer and the decoder under test. It supersedes the fixed single-line stuck-at-1 inserter with three fault modes (stuck-at-1, stuck-at-0, bit-flip), a probability threshold, fixed or pseudo-random bit index, and multi-word bursts. A valid-qualified datapath with a registered output makes injection events cycle-accurate and reproducible from the LFSR seed.

---
 rtl/fault_inj_pkg.sv | 21 ++
 rtl/fault_inj_lfsr32.sv | 22 ++
 rtl/fault_injector.sv | 164 ++++++++++++++++
 tb/tb_fault_injector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_inj_pkg.sv
// Shared constants and types for the fault injection stage.
package fault_inj_pkg;

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_SA1  = 2'd1;
   localparam logic [1:0] MODE_SA0  = 2'd2;
   localparam logic [1:0] MODE_FLIP = 2'd3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/fault_inj_lfsr32.sv
// 32-bit maximal-length Galois LFSR; never reaches zero from a
// non-zero seed.
module fault_inj_lfsr32
   import fault_inj_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   output logic [31:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= SEED;
      end else if (clk_en) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/fault_injector.sv
// Runtime-configurable fault injection stage with bursts.
// Optional injection counter: define FAULT_INJ_COUNTER_EN.
module fault_injector
   import fault_inj_pkg::*;
#(
   parameter int          CODEWORD_LENGTH = 30,
   parameter int          IDX_WIDTH       = 5,
   parameter logic [31:0] LFSR_SEED       = 32'h0000_0001,
   parameter int          BURST_WIDTH     = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clk_en,
   input  logic                       i_cfg_valid,
   input  logic [1:0]                 i_mode,
   input  logic [31:0]                i_threshold,
   input  logic                       i_idx_random,
   input  logic [IDX_WIDTH-1:0]       i_fixed_idx,
   input  logic [BURST_WIDTH-1:0]     i_burst_len,
   input  logic                       i_force,
   input  logic                       i_valid,
   input  logic [CODEWORD_LENGTH-1:0] i_codeword,
   output logic                       o_valid,
   output logic [CODEWORD_LENGTH-1:0] o_codeword,
   output logic [CODEWORD_LENGTH-1:0] o_err_mask
`ifdef FAULT_INJ_COUNTER_EN
   ,
   output logic [31:0]                o_inject_count
`endif
);

   localparam logic [IDX_WIDTH:0] CLW = (IDX_WIDTH+1)'(CODEWORD_LENGTH);
   localparam logic [IDX_WIDTH-1:0] CLN = IDX_WIDTH'(CODEWORD_LENGTH);
   localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(CODEWORD_LENGTH - 1);
   localparam logic [BURST_WIDTH-1:0] B_ONE = BURST_WIDTH'(1);

   logic [1:0]                 mode;
   logic [31:0]                threshold;
   logic                       idx_random;
   logic [IDX_WIDTH-1:0]       fixed_idx;
   logic [BURST_WIDTH-1:0]     burst_len;

   state_t                     state;
   logic [IDX_WIDTH-1:0]       idx_lat;
   logic [BURST_WIDTH-1:0]     remaining;
   logic                       force_pend;
   logic [31:0]                lfsr;

   logic                       trig;
   logic                       burst_word;
   logic                       fault;
   logic [IDX_WIDTH-1:0]       rnd_idx;
   logic [IDX_WIDTH-1:0]       fix_idx;
   logic [IDX_WIDTH-1:0]       sel_idx;
   logic [IDX_WIDTH-1:0]       nxt_idx;
   logic [IDX_WIDTH-1:0]       cur_idx;
   logic [BURST_WIDTH-1:0]     blen_eff;
   logic [CODEWORD_LENGTH-1:0] mask;
   logic [CODEWORD_LENGTH-1:0] word;

   fault_inj_lfsr32 #(
      .SEED   (LFSR_SEED)
   ) u_lfsr (
      .clk    (i_clk),
      .rst    (i_rst),
      .clk_en (i_clk_en),
      .value  (lfsr)
   );

   always_comb begin
      // single conditional subtract folds the index into range
      rnd_idx = ({1'b0, lfsr[IDX_WIDTH-1:0]} >= CLW)
              ? lfsr[IDX_WIDTH-1:0] - CLN
              : lfsr[IDX_WIDTH-1:0];
      fix_idx = ({1'b0, fixed_idx} >= CLW) ? LAST : fixed_idx;
      sel_idx = idx_random ? rnd_idx : fix_idx;
      nxt_idx = (idx_lat == LAST) ? '0 : idx_lat + 1'b1;
      blen_eff = (burst_len == '0) ? B_ONE : burst_len;

      trig = i_valid && (state == ST_IDLE) && (mode != MODE_OFF)
          && ((lfsr < threshold) || force_pend);
      burst_word = i_valid && (state == ST_BURST);
      cur_idx = burst_word ? nxt_idx : sel_idx;
      fault = trig || (burst_word && (mode != MODE_OFF));
      mask = fault ? (CODEWORD_LENGTH'(1) << cur_idx) : '0;

      word = i_codeword;
      unique case (mode)
         MODE_SA1:  word = i_codeword | mask;
         MODE_SA0:  word = i_codeword & ~mask;
         MODE_FLIP: word = i_codeword ^ mask;
         default:   word = i_codeword;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mode       <= MODE_OFF;
         threshold  <= '0;
         idx_random <= 1'b0;
         fixed_idx  <= '0;
         burst_len  <= B_ONE;
         state      <= ST_IDLE;
         idx_lat    <= '0;
         remaining  <= '0;
         force_pend <= 1'b0;
         o_valid    <= 1'b0;
         o_codeword <= '0;
         o_err_mask <= '0;
      end else if (i_clk_en) begin
         o_valid    <= i_valid;
         o_codeword <= i_valid ? word : '0;
         o_err_mask <= i_valid ? mask : '0;

         if (i_cfg_valid) begin
            mode       <= i_mode;
            threshold  <= i_threshold;
            idx_random <= i_idx_random;
            fixed_idx  <= i_fixed_idx;
            burst_len  <= i_burst_len;
         end

         force_pend <= i_force
                    | (force_pend
                       & ~(trig | (i_valid & (mode == MODE_OFF))));

         unique case (state)
            ST_IDLE: begin
               if (trig && (blen_eff > B_ONE)) begin
                  state     <= ST_BURST;
                  idx_lat   <= sel_idx;
                  remaining <= blen_eff - B_ONE;
               end
            end
            ST_BURST: begin
               if (i_valid) begin
                  idx_lat   <= nxt_idx;
                  remaining <= remaining - B_ONE;
               end
               // a config write abandons the burst after this word
               if (i_cfg_valid || (i_valid && remaining == B_ONE)) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef FAULT_INJ_COUNTER_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_inject_count <= '0;
      end else if (i_clk_en) begin
         if (i_cfg_valid) begin
            o_inject_count <= '0;
         end else if (i_valid && fault && (o_inject_count != '1)) begin
            o_inject_count <= o_inject_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fault_injector.sv
// Randomized scoreboard bench for fault_injector against a
// behavioural model of the injection rules.
module tb_fault_injector;

   localparam int CL = 30;
   localparam logic [31:0] SEED = 32'h0000_0001;

   typedef struct packed {
      logic [CL-1:0] cw;
      logic [CL-1:0] mask;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          clk_en;
   logic          cfg_valid;
   logic [1:0]    mode;
   logic [31:0]   threshold;
   logic          idx_random;
   logic [4:0]    fixed_idx;
   logic [3:0]    burst_len;
   logic          force_in;
   logic          valid;
   logic [CL-1:0] codeword;
   logic          o_valid;
   logic [CL-1:0] o_codeword;
   logic [CL-1:0] o_err_mask;
`ifdef FAULT_INJ_COUNTER_EN
   logic [31:0]   o_inject_count;
`endif

   int n_checks = 0;
   int n_pass = 0;

   exp_t q[$];

   logic [1:0]  m_mode;
   logic [31:0] m_thr;
   logic        m_rand;
   int          m_fix;
   int          m_blen;
   logic [31:0] m_lfsr;
   bit          m_pend;
   int          m_left;
   int          m_bidx;
   logic [31:0] m_cnt;

   bit            en_q;
   logic [31:0]   exp_cnt;
   logic [CL-1:0] snap_cw;
   logic [CL-1:0] snap_mask;
   logic          snap_v;

   always #5 clk = ~clk;

   fault_injector #(
      .CODEWORD_LENGTH (CL),
      .IDX_WIDTH       (5),
      .LFSR_SEED       (SEED),
      .BURST_WIDTH     (4)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_clk_en       (clk_en),
      .i_cfg_valid    (cfg_valid),
      .i_mode         (mode),
      .i_threshold    (threshold),
      .i_idx_random   (idx_random),
      .i_fixed_idx    (fixed_idx),
      .i_burst_len    (burst_len),
      .i_force        (force_in),
      .i_valid        (valid),
      .i_codeword     (codeword),
      .o_valid        (o_valid),
      .o_codeword     (o_codeword),
      .o_err_mask     (o_err_mask)
`ifdef FAULT_INJ_COUNTER_EN
      ,
      .o_inject_count (o_inject_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   // polynomial x^32+x^22+x^2+x+1, Galois form, shifting right
   function automatic logic [31:0] poly_step(input logic [31:0] s);
      int taps[4] = '{32, 22, 2, 1};
      logic [31:0] t = 0;
      foreach (taps[k]) t = t | (32'd1 << (taps[k] - 1));
      return s[0] ? ((s >> 1) ^ t) : (s >> 1);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_thr = 0; m_rand = 0; m_fix = 0; m_blen = 1;
      m_lfsr = SEED; m_pend = 0; m_left = 0; m_bidx = 0; m_cnt = 0;
      q.delete();
   endtask

   task automatic model_step();
      logic [CL-1:0] one = 1;
      logic [CL-1:0] mask = 0;
      logic [CL-1:0] cw = codeword;
      int idx;
      bit was_burst = (m_left > 0);
      if (valid) begin
         if (was_burst) begin
            idx = (m_bidx + 1) % CL;
            m_bidx = idx;
            m_left--;
            if (m_mode != 0) mask = one << idx;
         end else if (m_mode != 0 && (m_lfsr < m_thr || m_pend)) begin
            if (m_rand) idx = int'(m_lfsr % 32) % CL;
            else idx = (m_fix > CL - 1) ? CL - 1 : m_fix;
            mask = one << idx;
            m_pend = 0;
            m_left = ((m_blen == 0) ? 1 : m_blen) - 1;
            m_bidx = idx;
         end else if (m_mode == 0) begin
            m_pend = 0;
         end
         case (m_mode)
            2'd1: cw = cw | mask;
            2'd2: cw = cw & ~mask;
            2'd3: cw = cw ^ mask;
            default: ;
         endcase
         if (mask != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
         q.push_back('{cw: cw, mask: mask});
      end
      if (force_in) m_pend = 1;
      if (cfg_valid) begin
         if (was_burst) m_left = 0;
         m_mode = mode; m_thr = threshold; m_rand = idx_random;
         m_fix = int'(fixed_idx); m_blen = int'(burst_len);
         m_cnt = 0;
      end
      m_lfsr = poly_step(m_lfsr);
   endtask

   task automatic step();
      if (clk_en && !rst) model_step();
      @(posedge clk);
      #2;
      valid = 0; force_in = 0; cfg_valid = 0;
   endtask

   task automatic cfg(input logic [1:0] md, input logic [31:0] th,
                      input logic rn, input logic [4:0] fx,
                      input logic [3:0] bl);
      cfg_valid = 1; mode = md; threshold = th; idx_random = rn;
      fixed_idx = fx; burst_len = bl;
      step();
   endtask

   task automatic word(input logic [CL-1:0] w);
      valid = 1; codeword = w;
      step();
   endtask

   always @(posedge clk) begin
      en_q = clk_en && !rst;
      exp_cnt = m_cnt;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk("reset_out", {o_valid, o_codeword, o_err_mask}, 0);
         snap_v = 0; snap_cw = 0; snap_mask = 0;
`ifdef FAULT_INJ_COUNTER_EN
         chk("reset_count", o_inject_count, 0);
`endif
      end else if (!en_q) begin
         chk("frozen_out", {o_valid, o_codeword, o_err_mask},
             {snap_v, snap_cw, snap_mask});
      end else begin
         if (o_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("codeword", o_codeword, e.cw);
               chk("err_mask", o_err_mask, e.mask);
            end
         end else begin
            chk("idle_zero", {o_codeword, o_err_mask}, 0);
         end
         snap_v = o_valid; snap_cw = o_codeword; snap_mask = o_err_mask;
`ifdef FAULT_INJ_COUNTER_EN
         chk("inject_count", o_inject_count, exp_cnt);
`endif
      end
   end

   initial begin
      rst = 1; clk_en = 1; cfg_valid = 0; mode = 0; threshold = 0;
      idx_random = 0; fixed_idx = 0; burst_len = 1; force_in = 0;
      valid = 0; codeword = 0;
      snap_v = 0; snap_cw = 0; snap_mask = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 0;

      // stuck-at-1 on bit 28 of a zero word
      cfg(2'd1, 32'hFFFF_FFFF, 0, 5'd28, 4'd1);
      word('0);
      step();
      // stuck-at-0 on bit 0 of all-ones
      cfg(2'd2, 32'hFFFF_FFFF, 0, 5'd0, 4'd1);
      word('1);
      step();
      // forced single flip with threshold 0
      cfg(2'd3, 32'h0, 0, 5'd4, 4'd1);
      force_in = 1;
      step();
      word(30'h155);
      word(30'h155);
      word(30'h2AA);
      // burst of three wrapping past bit 29
      cfg(2'd3, 32'h0, 0, 5'd29, 4'd3);
      force_in = 1;
      step();
      for (int i = 0; i < 4; i++) begin
         word(30'($urandom));
         step();
         step();
      end
      // clamp of an out-of-range fixed index
      cfg(2'd1, 32'hFFFF_FFFF, 0, 5'd31, 4'd0);
      word('0);

      // random index, always injecting
      cfg(2'd3, 32'hFFFF_FFFF, 1, 5'd0, 4'd1);
      for (int i = 0; i < 10000; i++) word(30'($urandom));

      // reset in the middle of a long burst
      cfg(2'd3, 32'h0, 1, 5'd0, 4'd8);
      force_in = 1;
      step();
      word(30'h0);
      word(30'h0);
      rst = 1;
      model_reset();
      step();
      step();
      rst = 0;
      clk_en = 0;
      for (int i = 0; i < 4; i++) begin
         valid = 1; codeword = 30'($urandom);
         cfg_valid = 1; mode = 2'd1; threshold = '1;
         step();
      end
      clk_en = 1;
      word(30'h3);
      cfg(2'd3, 32'hFFFF_FFFF, 1, 5'd0, 4'd1);
      for (int i = 0; i < 20; i++) word(30'($urandom));

      // mixed random traffic
      for (int i = 0; i < 3000; i++) begin
         clk_en = ($urandom % 10) != 0;
         valid = ($urandom % 4) != 0;
         codeword = 30'($urandom);
         force_in = ($urandom % 16) == 0;
         if ($urandom % 40 == 0) begin
            cfg_valid = 1;
            mode = 2'($urandom);
            case ($urandom % 3)
               0: threshold = 32'h0;
               1: threshold = 32'hFFFF_FFFF;
               default: threshold = $urandom;
            endcase
            idx_random = 1'($urandom);
            fixed_idx = 5'($urandom);
            burst_len = 4'($urandom);
         end
         step();
      end
      clk_en = 1;
      repeat (3) step();
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
